// File: rtl/ddr_dac_sequencer_if.sv
// Sample-source handshakes plus the registered ODDR word bus of the DAC sequencer.
// Latency: none (wiring only).
// Backpressure: a_ready/b_ready are driven by the sequencer; sources hold data/valid until accepted.
interface ddr_dac_sequencer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          frame;

    // Sample sources / observers of the output word
    modport master (
        output a_data, a_valid, b_data, b_valid,
        input  a_ready, b_ready, d1, d2, frame
    );

    // Sequencer side
    modport slave (
        input  a_data, a_valid, b_data, b_valid,
        output a_ready, b_ready, d1, d2, frame
    );
endinterface

// File: rtl/ddr_dac_sequencer.sv
// Trains, aligns and then streams two sample channels onto the ODDR D1/D2 words.
// Latency: one clk_in cycle from accepted sample to d1/d2.
// Backpressure: readies low in IDLE/TRAIN, joint in ALIGN, always high in RUN (held sample on underflow).
module ddr_dac_sequencer #(
    parameter int DW        = 16,
    parameter int TRAIN_LEN = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 uf_clr,
    output logic [1:0]           state,
    output logic [15:0]          uf_count,
    ddr_dac_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_ALIGN = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    localparam int            CW       = (TRAIN_LEN > 2) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TRAIN_LEN - 1);
    localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] PAT      = {(DW/2){2'b10}};

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d1_q, d1_d;
    logic [DW-1:0] d2_q, d2_d;
    logic          frame_q, frame_d;
    logic [15:0]   uf_q, uf_d;
    logic          rdy;

    // Readies depend only on the registered mode and the current valids
    always_comb begin
        rdy = 1'b0;
        case (state_q)
            S_ALIGN: rdy = bus.a_valid & bus.b_valid;
            S_RUN:   rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
    end

    // Next mode, output words and underflow accounting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        frame_d = 1'b0;
        uf_d    = uf_q;
        if (!enable) begin
            // Dropping enable always parks the bus at mid-scale, even over a last RUN handshake
            state_d = S_IDLE;
            cnt_d   = '0;
            d1_d    = MID;
            d2_d    = MID;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_TRAIN;
                    cnt_d   = '0;
                    d1_d    = PAT;
                    d2_d    = ~PAT;
                end
                S_TRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_ALIGN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ALIGN: begin
                    // First pair is only taken when both channels have a sample
                    if (bus.a_valid && bus.b_valid) begin
                        state_d = S_RUN;
                        d1_d    = bus.a_data;
                        d2_d    = bus.b_data;
                        frame_d = 1'b1;
                    end
                end
                default: begin
                    if (bus.a_valid) begin
                        d1_d = bus.a_data;
                    end
                    if (bus.b_valid) begin
                        d2_d = bus.b_data;
                    end
                    // One count per cycle with any missing sample, saturating
                    if ((!bus.a_valid || !bus.b_valid) && (uf_q != 16'hFFFF)) begin
                        uf_d = uf_q + 16'd1;
                    end
                end
            endcase
        end
        if (uf_clr) begin
            uf_d = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d1_q    <= MID;
            d2_q    <= MID;
            frame_q <= 1'b0;
            uf_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            frame_q <= frame_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.a_ready = rdy;
    assign bus.b_ready = rdy;
    assign bus.d1      = d1_q;
    assign bus.d2      = d2_q;
    assign bus.frame   = frame_q;
    assign state       = state_q;
    assign uf_count    = uf_q;
endmodule

// File: tb/tb_ddr_dac_sequencer.sv
// Scoreboard bench for ddr_dac_sequencer: directed stimulus pushes expectations, a negedge monitor checks them.
// Latency: expectations are stamped with the cycle in which they must be visible.
// Backpressure: sources follow the ready/valid rule and hold data until accepted.
module tb_ddr_dac_sequencer;
    localparam logic [15:0] MID  = 16'h8000;
    localparam logic [15:0] PAT  = 16'hAAAA;
    localparam logic [15:0] NPAT = 16'h5555;

    logic        clk_in;
    logic        rst_n;
    logic        enable;
    logic        uf_clr;
    logic [1:0]  state;
    logic [15:0] uf_count;

    ddr_dac_sequencer_if #(.DW(16)) bus ();

    ddr_dac_sequencer #(.DW(16), .TRAIN_LEN(64)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .uf_clr   (uf_clr),
        .state    (state),
        .uf_count (uf_count),
        .bus      (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  st;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        fr;
        logic        ar;
        logic        br;
        int          uf;   // -1: not checked
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state kept by the bench for the RUN phase
    logic [15:0] last_a, last_b;
    int          uf_m;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic cmp(input exp_t e);
        n_cmp++;
        if (state !== e.st || bus.d1 !== e.d1 || bus.d2 !== e.d2 || bus.frame !== e.fr ||
            bus.a_ready !== e.ar || bus.b_ready !== e.br ||
            (e.uf >= 0 && uf_count !== 16'(e.uf))) begin
            n_err++;
            $display("FAIL %s cyc=%0d got st=%0d d1=%h d2=%h fr=%b ar=%b br=%b uf=%h exp st=%0d d1=%h d2=%h fr=%b ar=%b br=%b uf=%0d",
                     e.name, cyc, state, bus.d1, bus.d2, bus.frame, bus.a_ready, bus.b_ready, uf_count,
                     e.st, e.d1, e.d2, e.fr, e.ar, e.br, e.uf);
        end
    endtask

    // Monitor: compare every expectation due in this cycle, away from the active edge
    always @(negedge clk_in) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else begin
                cmp(e);
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [1:0] st, input logic [15:0] e1,
                                input logic [15:0] e2, input logic fr, input logic ar,
                                input logic br, input int uf);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.st = st; e.d1 = e1; e.d2 = e2;
        e.fr = fr; e.ar = ar; e.br = br; e.uf = uf;
        return e;
    endfunction

    task automatic expect_now(input string nm, input logic [1:0] st, input logic [15:0] e1,
                              input logic [15:0] e2, input logic fr, input logic ar,
                              input logic br, input int uf);
        q.push_back(mk(nm, st, e1, e2, fr, ar, br, uf));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One RUN cycle: drive sources, expect the word from previous accepts, advance the reference
    task automatic run_cycle(input string nm, input logic av, input logic [15:0] ad,
                             input logic bv, input logic [15:0] bd, input logic clr, input logic fr);
        step();
        bus.a_valid = av; bus.a_data = ad;
        bus.b_valid = bv; bus.b_data = bd;
        uf_clr = clr;
        expect_now(nm, 2'd3, last_a, last_b, fr, 1'b1, 1'b1, uf_m);
        if (av) last_a = ad;
        if (bv) last_b = bd;
        if (clr) uf_m = 0;
        else if ((!av || !bv) && uf_m < 16'hFFFF) uf_m++;
    endtask

    // Starts in IDLE with enable just raised; returns on the last checked TRAIN cycle
    task automatic train_cycles(input int n, input int uf);
        for (int k = 0; k < n; k++) begin
            step();
            bus.a_valid = 1'b1; bus.b_valid = 1'b1;
            expect_now("train", 2'd1, PAT, NPAT, 1'b0, 1'b0, 1'b0, uf);
        end
    endtask

    // Hand-chosen RUN pattern: A missing for 3 cycles, B missing in the middle one
    localparam logic [7:0] A_VLD = 8'b1110_0011;  // bit i = cycle i
    localparam logic [7:0] B_VLD = 8'b1111_0111;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] av_pat, bv_pat;
        av_pat = A_VLD;
        bv_pat = B_VLD;
        rst_n = 1'b0; enable = 1'b0; uf_clr = 1'b0;
        bus.a_valid = 1'b0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_data = '0;
        repeat (3) @(posedge clk_in);
        #1;
        expect_now("reset", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);

        // IDLE with enable low: readies stay low even with valids up
        step();
        rst_n = 1'b1;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            expect_now("idle", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);
        end

        step();
        enable = 1'b1;
        expect_now("idle_en", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);
        train_cycles(64, 0);

        // ALIGN, nothing valid
        for (int k = 0; k < 10; k++) begin
            step();
            bus.a_valid = 1'b0; bus.b_valid = 1'b0;
            expect_now("align_idle", 2'd2, PAT, NPAT, 1'b0, 1'b0, 1'b0, 0);
        end
        // Only A valid: no transfer
        for (int k = 0; k < 5; k++) begin
            step();
            bus.a_valid = 1'b1; bus.a_data = 16'h1234;
            bus.b_valid = 1'b0; bus.b_data = 16'hABCD;
            expect_now("align_a_only", 2'd2, PAT, NPAT, 1'b0, 1'b0, 1'b0, 0);
        end
        step();
        bus.b_valid = 1'b1;
        expect_now("align_both", 2'd2, PAT, NPAT, 1'b0, 1'b1, 1'b1, 0);

        // RUN: first word is the aligned pair with frame, then ramps with underflows
        last_a = 16'h1234; last_b = 16'hABCD; uf_m = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle("run_ramp", av_pat[i], 16'h0100 + 16'(i), bv_pat[i], 16'h0200 + 16'(i),
                      1'b0, (i == 0));
        end
        run_cycle("run_uf3", 1'b1, 16'h0108, 1'b1, 16'h0208, 1'b0, 1'b0);
        run_cycle("run_after", 1'b1, 16'h0109, 1'b1, 16'h0209, 1'b0, 1'b0);

        // Saturation of the underflow counter, then clear against an underflow
        for (int i = 0; i < 70000; i++) begin
            run_cycle("uf_sat", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        run_cycle("uf_sat_clr", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_cycle("uf_cleared", 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b0, 1'b0);
        run_cycle("uf_one", 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0);

        // Drop enable mid-RUN with a live handshake: still RUN this cycle, MID afterwards
        step();
        enable = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 16'h7777;
        bus.b_valid = 1'b1; bus.b_data = 16'h8888;
        expect_now("run_drop", 2'd3, last_a, last_b, 1'b0, 1'b1, 1'b1, uf_m);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_now("dropped", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, uf_m);
        end
        step();
        enable = 1'b1;
        expect_now("reenable", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, uf_m);
        train_cycles(64, uf_m);
        for (int k = 0; k < 3; k++) begin
            step();
            bus.a_valid = 1'b0; bus.b_valid = 1'b0;
            expect_now("realign", 2'd2, PAT, NPAT, 1'b0, 1'b0, 1'b0, uf_m);
        end

        // Third bring-up, interrupted by async reset mid-TRAIN
        step();
        enable = 1'b0;
        expect_now("align_drop", 2'd2, PAT, NPAT, 1'b0, 1'b0, 1'b0, uf_m);
        step();
        enable = 1'b1;
        expect_now("idle_en2", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, uf_m);
        train_cycles(30, uf_m);
        step();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 cmp(mk("async_rst_now", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0));
        expect_now("async_rst", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);
        step();
        expect_now("in_rst", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);
        step();
        rst_n = 1'b1;
        enable = 1'b0;
        expect_now("post_rst", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);
        step();
        expect_now("post_rst_idle", 2'd0, MID, MID, 1'b0, 1'b0, 1'b0, 0);

        step();
        step();
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain leftover=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
